branch_pc_ctrl: RTL and testbench

- Consumer end of the ID-stage branch comparators (equal, signed <=0, signed >0).
- Takes their condition flags plus the decoded branch/jump op.
- Resolves taken/not-taken, computes the target and owns the fetch PC register.
- Sits between the ID-stage comparators/decoder and instruction fetch. Honours the hazard-unit stall and the instruction-memory ready handshake, so a redirect is never lost.

---
 rtl/br_pkg.sv | 42 ++++
 rtl/br_target_gen.sv | 37 +++
 rtl/branch_pc_ctrl.sv | 120 ++++++++++++
 tb/tb_branch_pc_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/br_pkg.sv
// Shared types and constants for the ID-stage branch/PC controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package br_pkg;

  // Decoded branch/jump operation carried from ID.
  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_BEQ  = 3'd1,
    OP_BNE  = 3'd2,
    OP_BLEZ = 3'd3,
    OP_BGTZ = 3'd4,
    OP_J    = 3'd5,
    OP_JAL  = 3'd6,
    OP_JR   = 3'd7
  } br_op_e;

  // IDLE: normal fetch. PENDING: a taken target is waiting for imem_ready.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } br_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // Taken decision from the comparator flags; unconditional jumps always take.
  function automatic logic br_cond_taken(input br_op_e op, input logic eq,
                                         input logic lez, input logic gtz);
    logic t;
    t = 1'b0;
    case (op)
      OP_BEQ:                t = eq;
      OP_BNE:                t = ~eq;
      OP_BLEZ:               t = lez;
      OP_BGTZ:               t = gtz;
      OP_J, OP_JAL, OP_JR:   t = 1'b1;
      default:               t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/br_target_gen.sv
// Combinational branch/jump target and JAL link address generator.
// Latency: zero cycles (purely combinational).
// Backpressure: none; outputs follow inputs.
// Ports: id_br_op/id_pc/id_imm16/id_index26/id_rs_data in; target, link_pc out.
module br_target_gen
  import br_pkg::*;
(
  input  logic [2:0]  id_br_op,
  input  logic [31:0] id_pc,
  input  logic [15:0] id_imm16,
  input  logic [25:0] id_index26,
  input  logic [31:0] id_rs_data,
  output logic [31:0] target,
  output logic [31:0] link_pc
);

  logic [31:0] pc_plus4;
  logic [31:0] br_offset;
  br_op_e      op;

  assign op        = br_op_e'(id_br_op);
  assign pc_plus4  = id_pc + 32'd4;
  // Word offset: sign-extend then scale by 4.
  assign br_offset = {{14{id_imm16[15]}}, id_imm16, 2'b00};
  // Delay slot sits at id_pc + 4, so JAL returns past it.
  assign link_pc   = id_pc + 32'd8;

  always_comb begin
    target = pc_plus4 + br_offset;
    case (op)
      OP_J, OP_JAL: target = {pc_plus4[31:28], id_index26, 2'b00};
      OP_JR:        target = id_rs_data;
      default:      target = pc_plus4 + br_offset;
    endcase
  end

endmodule

// File: rtl/branch_pc_ctrl.sv
// Resolves ID-stage branches/jumps, owns the fetch PC and branch statistics.
// Latency: taken target reaches pc one cycle after resolve with imem_ready high.
// Backpressure: stall freezes everything; !imem_ready parks the target in PENDING.
// Ports: clk/reset; stall, imem_ready; id_* decode and cmp_* flags in;
//        pc, redirect, br_taken, link_pc, br_cnt, taken_cnt out.
module branch_pc_ctrl
  import br_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             imem_ready,
  input  logic             id_valid,
  input  logic [2:0]       id_br_op,
  input  logic             cmp_eq,
  input  logic             cmp_lez,
  input  logic             cmp_gtz,
  input  logic [31:0]      id_pc,
  input  logic [15:0]      id_imm16,
  input  logic [25:0]      id_index26,
  input  logic [31:0]      id_rs_data,
  output logic [31:0]      pc,
  output logic             redirect,
  output logic             br_taken,
  output logic [31:0]      link_pc,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  br_state_e   state, state_nxt;
  logic [31:0] pend_target;
  logic [31:0] target;
  logic        resolve;
  logic        taken;

  logic [31:0] pc_nxt;
  logic [31:0] pend_nxt;
  logic        redirect_nxt;

  br_target_gen u_target (
    .id_br_op   (id_br_op),
    .id_pc      (id_pc),
    .id_imm16   (id_imm16),
    .id_index26 (id_index26),
    .id_rs_data (id_rs_data),
    .target     (target),
    .link_pc    (link_pc)
  );

  // While a target is pending, ID is not consumed: no resolve, no counting.
  assign resolve  = id_valid & ~stall & (state == ST_IDLE)
                  & (br_op_e'(id_br_op) != OP_NONE);
  assign taken    = br_cond_taken(br_op_e'(id_br_op), cmp_eq, cmp_lez, cmp_gtz);
  assign br_taken = resolve & taken;

  // State register plus datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      pend_target <= 32'h0;
      redirect    <= 1'b0;
      br_cnt      <= '0;
      taken_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      pend_target <= pend_nxt;
      redirect    <= redirect_nxt;
      // Saturating statistics.
      if (resolve && (br_cnt != {CNT_W{1'b1}}))
        br_cnt <= br_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (br_taken && (taken_cnt != {CNT_W{1'b1}}))
        taken_cnt <= taken_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (br_taken && !imem_ready) state_nxt = ST_PENDING;
      ST_PENDING: if (!stall && imem_ready)    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Output/datapath logic. br_taken already excludes stall.
  always_comb begin
    pc_nxt       = pc;
    pend_nxt     = pend_target;
    redirect_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (br_taken && imem_ready) begin
          pc_nxt       = target;
          redirect_nxt = 1'b1;
        end else if (br_taken) begin
          pend_nxt = target;
        end else if (!stall && imem_ready) begin
          pc_nxt = pc + 32'd4;
        end
      end
      ST_PENDING: begin
        // The parked target beats sequential increment.
        if (!stall && imem_ready) begin
          pc_nxt       = pend_target;
          redirect_nxt = 1'b1;
        end
      end
      default: begin
        pc_nxt = pc;
      end
    endcase
  end

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Directed bench for branch_pc_ctrl with a behavioural reference model.
module tb_branch_pc_ctrl;

  localparam int CW = 4;   // narrow counters so saturation is reachable

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic          imem_ready;
  logic          id_valid;
  logic [2:0]    id_br_op;
  logic          cmp_eq, cmp_lez, cmp_gtz;
  logic [31:0]   id_pc;
  logic [15:0]   id_imm16;
  logic [25:0]   id_index26;
  logic [31:0]   id_rs_data;
  logic [31:0]   pc;
  logic          redirect;
  logic          br_taken;
  logic [31:0]   link_pc;
  logic [CW-1:0] br_cnt;
  logic [CW-1:0] taken_cnt;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  branch_pc_ctrl #(.RESET_PC(32'h0000_3000), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .imem_ready (imem_ready),
    .id_valid   (id_valid),
    .id_br_op   (id_br_op),
    .cmp_eq     (cmp_eq),
    .cmp_lez    (cmp_lez),
    .cmp_gtz    (cmp_gtz),
    .id_pc      (id_pc),
    .id_imm16   (id_imm16),
    .id_index26 (id_index26),
    .id_rs_data (id_rs_data),
    .pc         (pc),
    .redirect   (redirect),
    .br_taken   (br_taken),
    .link_pc    (link_pc),
    .br_cnt     (br_cnt),
    .taken_cnt  (taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  logic [31:0] pend_q[$];
  bit          m_redirect;
  int          m_br, m_tk;
  int          cnt_max = (1 << CW) - 1;

  function automatic bit m_cond(input int op, input bit eq, input bit lez, input bit gtz);
    if (op == 1) return eq;
    if (op == 2) return !eq;
    if (op == 3) return lez;
    if (op == 4) return gtz;
    return (op >= 5);
  endfunction

  function automatic logic [31:0] m_target(input int op, input logic [31:0] p,
                                           input logic [15:0] imm, input logic [25:0] idx,
                                           input logic [31:0] rs);
    int off;
    logic [31:0] idx32;
    if (op == 7) return rs;
    if (op >= 5) begin
      idx32 = {6'b0, idx};
      return ((p + 32'd4) & 32'hF000_0000) | (idx32 * 32'd4);
    end
    off = $signed(imm);
    return p + 32'd4 + 32'(off * 4);
  endfunction

  function automatic bit m_br_taken();
    return !stall && (pend_q.size() == 0) && id_valid && (id_br_op != 3'd0)
           && m_cond(int'(id_br_op), cmp_eq, cmp_lez, cmp_gtz);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc = 32'h0000_3000;
      pend_q.delete();
      m_redirect = 0;
      m_br = 0;
      m_tk = 0;
    end else begin
      m_redirect = 0;
      if (pend_q.size() != 0) begin
        if (!stall && imem_ready) begin
          m_pc = pend_q.pop_front();
          m_redirect = 1;
        end
      end else if (!stall) begin
        if (id_valid && id_br_op != 3'd0) begin
          if (m_br < cnt_max) m_br++;
          if (m_cond(int'(id_br_op), cmp_eq, cmp_lez, cmp_gtz)) begin
            if (m_tk < cnt_max) m_tk++;
            if (imem_ready) begin
              m_pc = m_target(int'(id_br_op), id_pc, id_imm16, id_index26, id_rs_data);
              m_redirect = 1;
            end else begin
              pend_q.push_back(m_target(int'(id_br_op), id_pc, id_imm16, id_index26, id_rs_data));
            end
          end else if (imem_ready) begin
            m_pc = m_pc + 32'd4;
          end
        end else if (imem_ready) begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (run_cmp) begin
      check("cmp_pc",        pc,                   m_pc);
      check("cmp_redirect",  {31'b0, redirect},    {31'b0, m_redirect});
      check("cmp_br_taken",  {31'b0, br_taken},    {31'b0, m_br_taken()});
      check("cmp_link_pc",   link_pc,              id_pc + 32'd8);
      check("cmp_br_cnt",    {28'b0, br_cnt},      32'(m_br));
      check("cmp_taken_cnt", {28'b0, taken_cnt},   32'(m_tk));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic [2:0] op, input logic [31:0] p,
                        input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] rs);
    id_valid = v; id_br_op = op; id_pc = p; id_imm16 = imm; id_index26 = idx; id_rs_data = rs;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; imem_ready = 1'b1;
    cmp_eq = 1'b0; cmp_lez = 1'b0; cmp_gtz = 1'b0;
    set_op(1'b0, 3'd0, 32'h0, 16'h0, 26'h0, 32'h0);
    run_cmp = 1'b1;
    step(); step();
    check("reset_pc", pc, 32'h0000_3000);
    check("reset_cnt", {28'b0, br_cnt}, 32'h0);
    reset = 1'b0;

    // Sequential fetch.
    step(); step(); step();
    check("seq_pc", pc, 32'h0000_300C);
    check("seq_model_pc", m_pc, 32'h0000_300C);
    check("seq_redirect", {31'b0, redirect}, 32'h0);

    // BLEZ taken, backward offset -4 lands on 0x3004.
    set_op(1'b1, 3'd3, 32'h0000_3004, 16'hFFFF, 26'h0, 32'h0); cmp_lez = 1'b1;
    #1;
    check("blez_taken", {31'b0, br_taken}, 32'h1);
    check("blez_link", link_pc, 32'h0000_300C);
    step();
    check("blez_pc", pc, 32'h0000_3004);
    check("blez_redirect", {31'b0, redirect}, 32'h1);
    check("blez_cnts", {br_cnt, taken_cnt}, {24'b0, 4'd1, 4'd1});
    id_valid = 1'b0; cmp_lez = 1'b0;
    step();
    check("blez_pulse_end", {31'b0, redirect}, 32'h0);
    check("post_blez_pc", pc, 32'h0000_3008);

    // BEQ not taken.
    set_op(1'b1, 3'd1, 32'h0000_3004, 16'h0010, 26'h0, 32'h0); cmp_eq = 1'b0;
    #1;
    check("beq_nt", {31'b0, br_taken}, 32'h0);
    step();
    check("beq_pc", pc, 32'h0000_300C);
    check("beq_cnts", {br_cnt, taken_cnt}, {24'b0, 4'd2, 4'd1});

    // JR with imem not ready: target parks.
    set_op(1'b1, 3'd7, 32'h0000_3008, 16'h0, 26'h0, 32'h0000_4000); imem_ready = 1'b0;
    step();
    // ID contents are ignored while pending.
    set_op(1'b1, 3'd1, 32'h0000_300C, 16'h0004, 26'h0, 32'h0); cmp_eq = 1'b1;
    #1;
    check("pend_no_resolve", {31'b0, br_taken}, 32'h0);
    step(); step();
    check("pend_pc_held", pc, 32'h0000_300C);
    check("pend_cnts", {br_cnt, taken_cnt}, {24'b0, 4'd3, 4'd2});
    imem_ready = 1'b1;
    step();
    check("jr_pc", pc, 32'h0000_4000);
    check("jr_redirect", {31'b0, redirect}, 32'h1);
    id_valid = 1'b0; cmp_eq = 1'b0;
    step();
    check("jr_after", pc, 32'h0000_4004);

    // Stall beats resolve and increment.
    set_op(1'b1, 3'd4, 32'h0000_4000, 16'h0010, 26'h0, 32'h0); cmp_gtz = 1'b1; stall = 1'b1;
    step(); step();
    check("stall_pc", pc, 32'h0000_4004);
    check("stall_cnts", {br_cnt, taken_cnt}, {24'b0, 4'd3, 4'd2});
    stall = 1'b0;
    step();
    check("bgtz_pc", pc, 32'h0000_4044);
    check("bgtz_cnts", {br_cnt, taken_cnt}, {24'b0, 4'd4, 4'd3});
    id_valid = 1'b0; cmp_gtz = 1'b0;

    // Reset while pending discards the target.
    set_op(1'b1, 3'd7, 32'h0000_4044, 16'h0, 26'h0, 32'h0000_5000); imem_ready = 1'b0;
    step();
    id_valid = 1'b0;
    step();
    reset = 1'b1;
    #1;
    check("rst_pend_pc", pc, 32'h0000_3000);
    check("rst_pend_cnt", {br_cnt, taken_cnt}, 32'h0);
    step();
    reset = 1'b0; imem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("never_5000", {31'b0, pc == 32'h0000_5000}, 32'h0);
    end
    check("rst_seq_pc", pc, 32'h0000_3018);

    // J / JAL region-relative target and link.
    set_op(1'b1, 3'd5, 32'h1FFF_FFFC, 16'h0, 26'h000_0123, 32'h0);
    #1;
    check("j_link", link_pc, 32'h2000_0004);
    step();
    check("j_pc", pc, 32'h2000_048C);
    id_br_op = 3'd6;
    step();
    check("jal_pc", pc, 32'h2000_048C);
    check("jal_redirect", {31'b0, redirect}, 32'h1);

    // BNE taken with most negative offset.
    set_op(1'b1, 3'd2, 32'h2000_048C, 16'h8000, 26'h0, 32'h0); cmp_eq = 1'b0;
    step();
    check("bne_pc", pc, 32'h1FFE_0490);

    // PC wrap.
    set_op(1'b1, 3'd7, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFFC);
    step();
    check("wrap_top", pc, 32'hFFFF_FFFC);
    id_valid = 1'b0;
    step();
    check("wrap_zero", pc, 32'h0000_0000);

    // Stall while pending holds the target back.
    set_op(1'b1, 3'd7, 32'h0, 16'h0, 26'h0, 32'h0000_6000); imem_ready = 1'b0;
    step();
    id_valid = 1'b0; stall = 1'b1; imem_ready = 1'b1;
    step();
    check("pstall_pc", pc, 32'h0000_0000);
    check("pstall_redirect", {31'b0, redirect}, 32'h0);
    stall = 1'b0;
    step();
    check("pstall_release", pc, 32'h0000_6000);
    check("pre_sat_cnts", {br_cnt, taken_cnt}, {24'b0, 4'd5, 4'd5});

    // Saturation.
    set_op(1'b1, 3'd1, 32'h0000_6000, 16'h0001, 26'h0, 32'h0); cmp_eq = 1'b1;
    for (int i = 0; i < 14; i++) step();
    cmp_eq = 1'b0;
    step(); step();
    check("sat_cnts", {br_cnt, taken_cnt}, {24'b0, 4'hF, 4'hF});
    id_valid = 1'b0;
    step();

    run_cmp = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
